fib_checker: RTL



---
 rtl/fib_checker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fib_checker.sv
// fib_checker: receive-side Fibonacci stream checker.
// Tracks the last two accepted samples, checks each new sample against their
// modular sum, latches the first mismatch and counts matching samples.
module fib_checker #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CNT_W       = 16,
  parameter bit          STRICT_SEED = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  output logic             locked,
  output logic             error,
  output logic             wrapped,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_got
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TRACK,
    FAULT
  } state_t;

  state_t           r_state,   w_state_nxt;
  logic [WIDTH-1:0] r_prev0,   w_prev0_nxt;
  logic [WIDTH-1:0] r_prev1,   w_prev1_nxt;
  logic             r_locked,  w_locked_nxt;
  logic             r_error,   w_error_nxt;
  logic             r_wrapped, w_wrapped_nxt;
  logic [CNT_W-1:0] r_count,   w_count_nxt;
  logic [WIDTH-1:0] r_err_exp, w_err_exp_nxt;
  logic [WIDTH-1:0] r_err_got, w_err_got_nxt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_expected;
  logic             w_carry;
  logic             w_seed0_bad;
  logic             w_seed1_bad;

  assign w_sum       = {1'b0, r_prev0} + {1'b0, r_prev1};
  assign w_expected  = w_sum[WIDTH-1:0];
  assign w_carry     = w_sum[WIDTH];
  assign w_seed0_bad = STRICT_SEED && (in_value != '0);
  assign w_seed1_bad = STRICT_SEED && (in_value != WIDTH'(1));

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= EMPTY;
      r_prev0   <= '0;
      r_prev1   <= '0;
      r_locked  <= 1'b0;
      r_error   <= 1'b0;
      r_wrapped <= 1'b0;
      r_count   <= '0;
      r_err_exp <= '0;
      r_err_got <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev0   <= w_prev0_nxt;
      r_prev1   <= w_prev1_nxt;
      r_locked  <= w_locked_nxt;
      r_error   <= w_error_nxt;
      r_wrapped <= w_wrapped_nxt;
      r_count   <= w_count_nxt;
      r_err_exp <= w_err_exp_nxt;
      r_err_got <= w_err_got_nxt;
    end
  end

  // Next-state and next-output decode; clear overrides any sample this cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_prev0_nxt   = r_prev0;
    w_prev1_nxt   = r_prev1;
    w_locked_nxt  = r_locked;
    w_error_nxt   = r_error;
    w_wrapped_nxt = r_wrapped;
    w_count_nxt   = r_count;
    w_err_exp_nxt = r_err_exp;
    w_err_got_nxt = r_err_got;
    if (clear) begin
      w_state_nxt   = EMPTY;
      w_prev0_nxt   = '0;
      w_prev1_nxt   = '0;
      w_locked_nxt  = 1'b0;
      w_error_nxt   = 1'b0;
      w_wrapped_nxt = 1'b0;
      w_count_nxt   = '0;
      w_err_exp_nxt = '0;
      w_err_got_nxt = '0;
    end else if (in_valid) begin
      unique case (r_state)
        EMPTY: begin
          if (w_seed0_bad) begin
            w_state_nxt   = FAULT;
            w_error_nxt   = 1'b1;
            w_err_exp_nxt = '0;
            w_err_got_nxt = in_value;
          end else begin
            w_prev1_nxt = in_value;
            w_count_nxt = CNT_W'(1);
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_seed1_bad) begin
            w_state_nxt   = FAULT;
            w_error_nxt   = 1'b1;
            w_err_exp_nxt = WIDTH'(1);
            w_err_got_nxt = in_value;
          end else begin
            w_prev0_nxt  = r_prev1;
            w_prev1_nxt  = in_value;
            w_count_nxt  = CNT_W'(2);
            w_locked_nxt = 1'b1;
            w_state_nxt  = TRACK;
          end
        end
        TRACK: begin
          if (in_value == w_expected) begin
            w_prev0_nxt = r_prev1;
            w_prev1_nxt = in_value;
            if (r_count != '1) begin
              w_count_nxt = r_count + CNT_W'(1);
            end
            if (w_carry) begin
              w_wrapped_nxt = 1'b1;
            end
          end else begin
            w_state_nxt   = FAULT;
            w_error_nxt   = 1'b1;
            w_err_exp_nxt = w_expected;
            w_err_got_nxt = in_value;
            w_locked_nxt  = 1'b0;
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  assign locked       = r_locked;
  assign error        = r_error;
  assign wrapped      = r_wrapped;
  assign count        = r_count;
  assign err_expected = r_err_exp;
  assign err_got      = r_err_got;

endmodule
